uart_reg_responder: RTL and testbench
=====================================

# uart_reg_responder

Byte-level command responder sitting on the far side of the `uart` block. It consumes received bytes (`rx_data`/`rx_rcvd`) and decodes a 2- or 3-byte read/write command protocol. It issues single-cycle accesses on a simple 8-bit register bus and returns one response byte through the UART transmitter handshake (`tx_start`/`tx_data`/`tx_done`). It is the host-facing register access path for on-FPGA peripherals.

## Interface
- `TIMEOUT`, default 4096: idle clk cycles allowed between bytes of one frame before the partial frame is discarded.
- `clk` input 1: clock, same clock as `uart`. Timing is stated in clk cycles.
- `rst` input 1: reset, synchronous, active-high.
- `rx_data` input 8: received byte from `uart`.
- `rx_rcvd` input 1: one-cycle pulse; `rx_data` is valid in that cycle.
- `tx_start` output 1: request to transmit `tx_data`. Held until `tx_done`.
- `tx_data` output 8: byte to transmit. Held stable while `tx_start` is high.
- `tx_done` input 1: one-cycle pulse from `uart` when the last data bit completes.
- `bus_addr` output 8: register address. Valid while `bus_we` or `bus_re` is high.
- `bus_wdata` output 8: write data.
- `bus_we` output 1: one-cycle write strobe.
- `bus_re` output 1: one-cycle read strobe. The slave drives `bus_rdata` in the next cycle.
- `bus_rdata` input 8: read data, sampled exactly 1 cycle after `bus_re`.
- `overrun` output 1: one-cycle pulse when a byte arrives in a state that cannot accept it.

## Operation
- Frames:
  - Write: `0x57` ('W'), addr, data. Response: `0x4B` ('K').
  - Read: `0x52` ('R'), addr. Response: the read data byte.
  - Any other first byte: no bus access. Response: `0x3F` ('?').
- States:
  - IDLE
    - `rx_rcvd` with 'W' → GET_ADDR, mode write.
    - `rx_rcvd` with 'R' → GET_ADDR, mode read.
    - `rx_rcvd` with any other byte → SEND with `0x3F`.
  - GET_ADDR: on `rx_rcvd`, latch the address. Next state is GET_DATA (write) or BUS_RD (read).
  - GET_DATA: on `rx_rcvd`, latch the data → BUS_WR.
  - BUS_WR: `bus_we`=1 for one cycle → SEND with `0x4B`.
  - BUS_RD: `bus_re`=1 for one cycle → RD_CAP.
  - RD_CAP: register `bus_rdata` into `tx_data` → SEND.
  - SEND: `tx_start`=1 with `tx_data` stable. When `tx_done`=1 → IDLE, and `tx_start` is low from the next cycle.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA and is cleared by each `rx_rcvd`.
  - When it reaches `TIMEOUT`-1 without a byte, go to IDLE.
  - No bus access and no response are generated.
- Overrun:
  - `rx_rcvd` in BUS_WR, BUS_RD, RD_CAP or SEND: the byte is dropped and `overrun` pulses in the next cycle.
  - The state is unaffected.
- `bus_addr`/`bus_wdata` hold their last latched values between strobes.
- Invalid state encoding → IDLE on the next cycle.

## Timing
- Reset values: `tx_start`=0, `tx_data`=`0xFF`, `bus_addr`=0, `bus_wdata`=0, `bus_we`=0, `bus_re`=0, `overrun`=0; state IDLE; timeout counter 0.
- Reset mid-frame or mid-send:
  - All outputs return to reset values on the next edge.
  - `tx_start` drops even if `uart` is mid-byte.
  - Recovery relies on `uart` sharing `rst`.
- Write: final data byte `rx_rcvd` in cycle t → `bus_we`=1 in t+1 → `tx_start`=1, `tx_data`=`0x4B` from t+2.
- Read: addr byte `rx_rcvd` in t → `bus_re`=1 in t+1 → `bus_rdata` sampled in t+2 → `tx_start`=1 from t+3.
- Unknown command: `rx_rcvd` in t → `tx_start`=1 from t+1.
- `tx_done` ends SEND:
  - `tx_done` in cycle d: `tx_start`=0 in d+1.
  - This is well before the next `uart` baud tick, so the stop bit never auto-restarts a transmission.
- A new frame may begin on any `rx_rcvd` from the cycle after SEND exits.
- `tx_done` received outside SEND is ignored.

## Test plan
- Write: rx 0x57, 0x12, 0xA5 → one `bus_we` pulse with `bus_addr`=0x12 and `bus_wdata`=0xA5. Then `tx_start` with `tx_data`=0x4B, held until `tx_done`, then low the following cycle.
- Read: rx 0x52, 0x34, with the slave returning 0x5C the cycle after `bus_re` → `bus_re` pulse with `bus_addr`=0x34, then `tx_data`=0x5C with `tx_start` high at t+3.
- Unknown command: rx 0x00 → no bus strobes; `tx_data`=0x3F with `tx_start` at t+1. Then a 'R' frame completes normally.
- Timeout: rx 0x57, 0x12, then idle for `TIMEOUT`+10 cycles, then 0x52, 0x12 → no `bus_we`. The read executes and responds with the read data.
- Overrun: send 0x11 while in SEND → `overrun` pulses once and the response byte is unchanged. After `tx_done` the FSM is in IDLE.
- Reset in SEND: `tx_start`=0 and all bus outputs at reset values the next cycle. A following write frame behaves as in the first scenario.

Source files
------------

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: decodes 'W'/'R' byte frames from the UART into 8-bit register bus
// accesses and answers each frame with one response byte through the transmitter handshake.
module uart_reg_responder #(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rcvd,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       overrun
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_OK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, SEND} state_e;

    state_e state_q, state_d;
    logic wr_q, wr_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d, txd_q, txd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ovr_q, ovr_d;
    logic timed_out;

    assign timed_out = cnt_q == CW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        wr_d = wr_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        txd_d = txd_q;
        cnt_d = '0;
        // bytes landing while a bus access or response is in flight are dropped
        ovr_d = rx_rcvd && (state_q inside {BUS_WR, BUS_RD, RD_CAP, SEND});
        case (state_q)
            IDLE: if (rx_rcvd) begin
                if (rx_data == CMD_W || rx_data == CMD_R) begin
                    state_d = GET_ADDR;
                    wr_d = rx_data == CMD_W;
                end else begin
                    state_d = SEND;
                    txd_d = RSP_ERR;
                end
            end
            GET_ADDR: if (rx_rcvd) begin
                addr_d = rx_data;
                state_d = wr_q ? GET_DATA : BUS_RD;
            end else if (timed_out) state_d = IDLE;
            else cnt_d = cnt_q + CW'(1);
            GET_DATA: if (rx_rcvd) begin
                wdata_d = rx_data;
                state_d = BUS_WR;
            end else if (timed_out) state_d = IDLE;
            else cnt_d = cnt_q + CW'(1);
            BUS_WR: begin
                state_d = SEND;
                txd_d = RSP_OK;
            end
            BUS_RD: state_d = RD_CAP;
            RD_CAP: begin
                txd_d = bus_rdata;
                state_d = SEND;
            end
            SEND: if (tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            txd_q <= 8'hFF;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q <= wr_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            txd_q <= txd_d;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    assign tx_start = state_q == SEND;
    assign tx_data = txd_q;
    assign bus_addr = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we = state_q == BUS_WR;
    assign bus_re = state_q == BUS_RD;
    assign overrun = ovr_q;
endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: directed protocol scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a frame-level latency model of the responder.
module tb_uart_reg_responder;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_rcvd = 1'b0;
    logic tx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] bus_rdata = 8'h00;
    logic tx_start, bus_we, bus_re, overrun;
    logic [7:0] tx_data, bus_addr, bus_wdata;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_reg_responder #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rcvd(rx_rcvd),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .overrun(overrun)
    );

    // model: a completed frame occupies the responder for a fixed latency, then responds until tx_done
    byte unsigned frm[$];
    int m_op = 0;
    int m_lat = 0;
    int m_gap = 0;
    bit m_send = 0;
    bit m_ovr = 0;
    bit m_ok = 0;
    logic [7:0] m_txd, m_addr, m_wdata, m_cap;
    logic [27:0] exp_v, act_v;

    function automatic int op_len(int op);
        return op == 1 ? 2 : op == 2 ? 3 : 1;
    endfunction

    always @(negedge clk) begin
        exp_v = {m_send, m_txd, m_addr, m_wdata, m_op == 1 && m_lat == 1 && !m_send,
                 m_op == 2 && m_lat == 1 && !m_send, m_ovr};
        act_v = {tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, overrun};
        if (m_ok) begin
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL model t=%0t got{start,data,addr,wdata,we,re,ovr}=%h exp=%h", $time, act_v, exp_v);
            end
        end
        if (rst) begin
            frm.delete();
            m_op = 0; m_lat = 0; m_gap = 0; m_send = 0; m_ovr = 0; m_ok = 1;
            m_txd = 8'hFF; m_addr = 8'h00; m_wdata = 8'h00;
        end else begin
            m_ovr = 0;
            if (m_op != 0) begin
                if (rx_rcvd) m_ovr = 1;
                if (m_send) begin
                    if (tx_done) begin m_send = 0; m_op = 0; end
                end else begin
                    if (m_op == 2 && m_lat == 2) m_cap = bus_rdata;
                    m_lat++;
                    if (m_lat == op_len(m_op)) begin
                        m_send = 1;
                        m_txd = m_op == 1 ? 8'h4B : m_cap;
                    end
                end
            end else if (rx_rcvd) begin
                m_gap = 0;
                if (frm.size() == 0) begin
                    if (rx_data == 8'h57 || rx_data == 8'h52) frm.push_back(rx_data);
                    else begin m_op = 3; m_lat = 1; m_send = 1; m_txd = 8'h3F; end
                end else if (frm.size() == 1) begin
                    m_addr = rx_data;
                    if (frm[0] == 8'h52) begin frm.delete(); m_op = 2; m_lat = 1; end
                    else frm.push_back(rx_data);
                end else begin
                    m_wdata = rx_data;
                    frm.delete();
                    m_op = 1; m_lat = 1;
                end
            end else if (frm.size() != 0) begin
                m_gap++;
                if (m_gap == TO) begin frm.delete(); m_gap = 0; end
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(string nm, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, want);
        end
    endtask

    task automatic rx(logic [7:0] b);
        rx_rcvd = 1'b1; rx_data = b; cyc(); rx_rcvd = 1'b0;
    endtask

    task automatic done();
        tx_done = 1'b1; cyc(); tx_done = 1'b0;
    endtask

    task automatic write_frame();
        rx(8'h57); rx(8'h12); rx(8'hA5);
        chk("wr_we", 8'(bus_we), 8'h01);
        chk("wr_addr", bus_addr, 8'h12);
        chk("wr_wdata", bus_wdata, 8'hA5);
        chk("wr_re", 8'(bus_re), 8'h00);
        cyc();
        chk("wr_start", 8'(tx_start), 8'h01);
        chk("wr_data", tx_data, 8'h4B);
        chk("wr_we_low", 8'(bus_we), 8'h00);
        cyc(3);
        chk("wr_held", 8'(tx_start), 8'h01);
        done();
        chk("wr_start_low", 8'(tx_start), 8'h00);
    endtask

    initial begin
        cyc(3);
        chk("rst_start", 8'(tx_start), 8'h00);
        chk("rst_data", tx_data, 8'hFF);
        chk("rst_addr", bus_addr, 8'h00);
        chk("rst_strobes", {5'd0, bus_we, bus_re, overrun}, 8'h00);
        rst = 1'b0;
        cyc();
        write_frame();
        rx(8'h52); rx(8'h34);
        chk("rd_re", 8'(bus_re), 8'h01);
        chk("rd_addr", bus_addr, 8'h34);
        cyc(); bus_rdata = 8'h5C;
        chk("rd_cap_nostart", 8'(tx_start), 8'h00);
        cyc(); bus_rdata = 8'h00;
        chk("rd_start", 8'(tx_start), 8'h01);
        chk("rd_data", tx_data, 8'h5C);
        done();
        rx(8'h00);
        chk("unk_start", 8'(tx_start), 8'h01);
        chk("unk_data", tx_data, 8'h3F);
        chk("unk_strobes", {6'd0, bus_we, bus_re}, 8'h00);
        done();
        rx(8'h52); rx(8'h77);
        chk("unk_rd_re", 8'(bus_re), 8'h01);
        cyc(); bus_rdata = 8'hC3;
        cyc(); bus_rdata = 8'h00;
        chk("unk_rd_data", tx_data, 8'hC3);
        done();
        rx(8'h57); rx(8'h12);
        cyc(TO + 10);
        chk("to_no_we", 8'(bus_we), 8'h00);
        rx(8'h52); rx(8'h12);
        chk("to_rd_re", 8'(bus_re), 8'h01);
        cyc(); bus_rdata = 8'h9A;
        cyc(); bus_rdata = 8'h00;
        chk("to_rd_data", tx_data, 8'h9A);
        done();
        rx(8'h57); rx(8'h12); cyc(TO - 1); rx(8'h66);
        chk("to_edge_accept", 8'(bus_we), 8'h01);
        cyc(); done();
        rx(8'h57); rx(8'h12); cyc(TO); rx(8'h66);
        chk("to_edge_expired", 8'(tx_start), 8'h01);
        chk("to_edge_err", tx_data, 8'h3F);
        rx(8'h11);
        chk("ovr_pulse", 8'(overrun), 8'h01);
        chk("ovr_data", tx_data, 8'h3F);
        cyc();
        chk("ovr_once", 8'(overrun), 8'h00);
        done();
        rx(8'h57);
        chk("ovr_idle", 8'(tx_start), 8'h00);
        rx(8'h01); rx(8'h02); cyc(); done();
        rx(8'h00);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_send_start", 8'(tx_start), 8'h00);
        chk("rst_send_data", tx_data, 8'hFF);
        chk("rst_send_addr", bus_addr, 8'h00);
        chk("rst_send_wdata", bus_wdata, 8'h00);
        write_frame();
        for (int i = 0; i < 12000; i++) begin
            int p;
            int sel;
            p = ((i / 1500) % 2) != 0 ? 20 : 3;
            sel = $urandom_range(9);
            rx_rcvd = $urandom_range(p - 1) == 0;
            rx_data = sel < 4 ? 8'h57 : sel < 7 ? 8'h52 : 8'($urandom);
            tx_done = $urandom_range(5) == 0;
            bus_rdata = 8'($urandom);
            rst = $urandom_range(799) == 0;
            cyc();
        end
        rx_rcvd = 1'b0; tx_done = 1'b0; rst = 1'b0;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
